// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory geometry, reset vector and the fetch entry layout.
package cpu_pkg;

   localparam int unsigned INSTR_NUM = 1024;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order fetch FIFO; slot 0 is always the head, so head outputs come straight from flops.
module fetch_buffer
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t push_data_i,
   output logic         full_o,
   output logic         head_valid_o,
   output fetch_entry_t head_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fetch_entry_t  slot_q [DEPTH];
   logic [CW-1:0] count_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         slot_q[0] <= '0;
         slot_q[1] <= '0;
         count_q   <= '0;
      end else if (flush_i) begin
         count_q <= '0;
      end else begin
         unique case ({push_i, pop_i})
            2'b10: begin
               if (count_q == '0) slot_q[0] <= push_data_i;
               else               slot_q[1] <= push_data_i;
               count_q <= count_q + 1'b1;
            end
            2'b01: begin
               slot_q[0] <= slot_q[1];
               count_q   <= count_q - 1'b1;
            end
            2'b11: begin
               // Simultaneous push/pop: new entry lands behind whatever remains after the pop.
               if (count_q == FULL_CNT) begin
                  slot_q[0] <= slot_q[1];
                  slot_q[1] <= push_data_i;
               end else begin
                  slot_q[0] <= push_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      full_o       = (count_q == FULL_CNT);
      head_valid_o = (count_q != '0);
      head_o       = head_valid_o ? slot_q[0] : '{pc: '0, instr: NOP_INSTR};
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, reads instruction memory and feeds ID through a 2-entry buffer.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
   parameter int unsigned INSTR_NUM = cpu_pkg::INSTR_NUM,
   parameter int unsigned DEPTH     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] pc_addr_o,
   input  logic [31:0] instr_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        halt_i,
   output logic        if_valid_o,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_pc_plus4_o,
   input  logic        id_ready_i,
   output logic        misalign_o
);

   import cpu_pkg::*;

   localparam logic [31:0] PC_SPAN = 32'(INSTR_NUM * 4);

   logic [31:0]  pc_q;
   logic [31:0]  pc_inc;
   logic [31:0]  pc_seq;
   logic         misalign_q;
   logic         pop;
   logic         cap;
   logic         buf_full;
   fetch_entry_t head;
   fetch_entry_t push_data;

   always_comb begin
      pop       = if_valid_o & id_ready_i;
      cap       = ~redirect_i & ~halt_i & (~buf_full | pop);
      pc_inc    = pc_q + 32'd4;
      pc_seq    = (pc_inc >= PC_SPAN) ? '0 : pc_inc;
      push_data = '{pc: pc_q, instr: instr_i};
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         if (redirect_i) begin
            pc_q <= {redirect_pc_i[31:2], 2'b00};
            if (|redirect_pc_i[1:0]) misalign_q <= 1'b1;
         end else if (cap) begin
            pc_q <= pc_seq;
         end
      end
   end

   fetch_buffer #(
      .DEPTH (DEPTH)
   ) u_fetch_buffer (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (cap),
      .pop_i        (pop),
      .flush_i      (redirect_i),
      .push_data_i  (push_data),
      .full_o       (buf_full),
      .head_valid_o (if_valid_o),
      .head_o       (head)
   );

   always_comb begin
      pc_addr_o     = pc_q;
      misalign_o    = misalign_q;
      if_pc_o       = head.pc;
      if_instr_o    = head.instr;
      if_pc_plus4_o = if_valid_o ? head.pc + 32'd4 : '0;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based fetch model checked every cycle plus directed literal checks.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_addr;
   logic [31:0] instr;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        id_ready;
   logic        misalign;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [1024];

   always #5 clk = ~clk;

   assign instr = mem[pc_addr[11:2]];

   instr_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .INSTR_NUM (1024),
      .DEPTH     (2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_n),
      .pc_addr_o     (pc_addr),
      .instr_i       (instr),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .halt_i        (halt),
      .if_valid_o    (if_valid),
      .if_instr_o    (if_instr),
      .if_pc_o       (if_pc),
      .if_pc_plus4_o (if_pc_plus4),
      .id_ready_i    (id_ready),
      .misalign_o    (misalign)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Reference model: an ordered queue of fetched {pc, instr} and a PC in a 4 KiB wrapping space.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_pc;
   logic        m_mis;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_pc  = 32'h0;
         m_mis = 1'b0;
      end else if (redirect) begin
         q.delete();
         if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
         m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         if (q.size() > 0 && id_ready) void'(q.pop_front());
         if (!halt && q.size() < 2) begin
            q.push_back('{pc: m_pc, instr: mem[(m_pc / 4) % 1024]});
            m_pc = (m_pc + 4) % 4096;
         end
      end
   end

   always @(negedge clk) begin
      chk("pc_addr", pc_addr, m_pc);
      chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
      chk("if_valid", {31'b0, if_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
      chk("if_pc", if_pc, (q.size() > 0) ? q[0].pc : 32'h0);
      chk("if_instr", if_instr, (q.size() > 0) ? q[0].instr : 32'h0);
      chk("if_pc_plus4", if_pc_plus4, (q.size() > 0) ? q[0].pc + 32'd4 : 32'h0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic restart(input logic rdy);
      rst_n = 1'b0;
      #1;
      id_ready = rdy;
      redirect = 1'b0;
      halt     = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | 32'(i * 3 + 1);
      rst_n       = 1'b0;
      id_ready    = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      halt        = 1'b0;
      repeat (2) tick();

      // Reset state
      chk("rst_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_pc_addr", pc_addr, 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
      chk("rst_plus4", if_pc_plus4, 32'h0);
      chk("rst_misalign", {31'b0, misalign}, 32'd0);

      // Streaming with ready held high
      rst_n = 1'b1;
      tick();
      chk("s1_pc", if_pc, 32'h0);
      chk("s1_instr", if_instr, 32'h1000_0001);
      chk("s1_plus4", if_pc_plus4, 32'd4);
      chk("s1_addr", pc_addr, 32'd4);
      tick();
      chk("s2_pc", if_pc, 32'd4);
      chk("s2_instr", if_instr, 32'h1000_0004);
      chk("s2_plus4", if_pc_plus4, 32'd8);
      tick();
      chk("s3_pc", if_pc, 32'd8);
      chk("s3_instr", if_instr, 32'h1000_0007);
      chk("s3_plus4", if_pc_plus4, 32'd12);
      chk("s3_addr", pc_addr, 32'd12);

      // Backpressure from reset
      restart(1'b0);
      repeat (5) tick();
      chk("bp_addr", pc_addr, 32'd8);
      chk("bp_head", if_pc, 32'h0);
      chk("bp_instr", if_instr, 32'h1000_0001);
      id_ready = 1'b1;
      tick();
      chk("bp_b", if_instr, 32'h1000_0004);
      tick();
      chk("bp_c", if_instr, 32'h1000_0007);
      chk("bp_c_pc", if_pc, 32'd8);

      // Redirect with a full buffer
      restart(1'b0);
      repeat (2) tick();
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      tick();
      chk("rd_flush", {31'b0, if_valid}, 32'd0);
      chk("rd_addr", pc_addr, 32'h40);
      redirect = 1'b0;
      id_ready = 1'b1;
      tick();
      chk("rd_valid", {31'b0, if_valid}, 32'd1);
      chk("rd_pc", if_pc, 32'h40);
      chk("rd_instr", if_instr, 32'h1000_0031);

      // Misaligned redirect, then back-to-back aligned redirect
      redirect    = 1'b1;
      redirect_pc = 32'h46;
      tick();
      chk("mis_addr", pc_addr, 32'h44);
      chk("mis_flag", {31'b0, misalign}, 32'd1);
      redirect_pc = 32'h80;
      tick();
      chk("mis_sticky", {31'b0, misalign}, 32'd1);
      chk("b2b_empty", {31'b0, if_valid}, 32'd0);
      chk("b2b_addr", pc_addr, 32'h80);

      // Wrap at the top of PC space
      redirect_pc = 32'd4092;
      tick();
      redirect = 1'b0;
      tick();
      chk("wrap_pc", if_pc, 32'd4092);
      chk("wrap_instr", if_instr, 32'h1000_0BFE);
      chk("wrap_plus4", if_pc_plus4, 32'd4096);
      chk("wrap_addr", pc_addr, 32'h0);
      tick();
      chk("wrap_next", if_pc, 32'h0);
      chk("mis_still", {31'b0, misalign}, 32'd1);

      // Halt drains the buffer; reset clears misalign
      restart(1'b0);
      chk("mis_clear", {31'b0, misalign}, 32'd0);
      repeat (2) tick();
      halt     = 1'b1;
      id_ready = 1'b1;
      tick();
      chk("h_b", if_pc, 32'd4);
      tick();
      chk("h_empty", {31'b0, if_valid}, 32'd0);
      chk("h_addr", pc_addr, 32'd8);
      tick();
      chk("h_hold", pc_addr, 32'd8);
      halt = 1'b0;
      tick();
      chk("h_resume", if_pc, 32'd8);
      chk("h_resume_instr", if_instr, 32'h1000_0007);

      // Asynchronous reset mid-stream
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'b0, if_valid}, 32'd0);
      chk("ar_addr", pc_addr, 32'h0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
